top_of_tops_debug_soc: RTL and testbench

TOP_OF_TOPS_DEBUG_SOC -- requirements
Module: top_of_tops

---
 rtl/top_of_tops_debug_soc_pkg.sv | 33 +++
 rtl/top_of_tops_debug_soc_mini_core.sv | 63 ++++++
 rtl/top_of_tops_debug_soc.sv | 103 ++++++++++
 tb/tb_top_of_tops_debug_soc.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/top_of_tops_debug_soc_pkg.sv
// top_of_tops_debug_soc_pkg: command codes, FSM encodings, opcodes and dump layout
package top_of_tops_debug_soc_pkg;
  localparam logic [7:0] CMD_WRITE_IM = 8'd1;
  localparam logic [7:0] CMD_RUN      = 8'd2;
  localparam logic [7:0] CMD_STEP     = 8'd3;
  localparam logic [7:0] CMD_SEND_BR  = 8'd4;
  localparam logic [7:0] CMD_SEND_DM  = 8'd5;
  localparam logic [7:0] CMD_SEND_PC  = 8'd6;
  localparam logic [7:0] CMD_STEP_GO  = 8'd7;
  localparam logic [9:0] S_IDLE      = 10'b00_0000_0001;
  localparam logic [9:0] S_WRITE_IM  = 10'b00_0000_0010;
  localparam logic [9:0] S_RUN       = 10'b00_0000_0100;
  localparam logic [9:0] S_STEP      = 10'b00_0000_1000;
  localparam logic [9:0] S_STEP_EXEC = 10'b00_0001_0000;
  localparam logic [9:0] S_SEND_PC   = 10'b00_0010_0000;
  localparam logic [9:0] S_SEND_BR   = 10'b00_0100_0000;
  localparam logic [9:0] S_SEND_DM   = 10'b00_1000_0000;
  localparam logic [9:0] S_WAIT_TX   = 10'b01_0000_0000;
  localparam logic [9:0] S_HALTED    = 10'b10_0000_0000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_HALT = 6'b111111;
  localparam logic [8:0] LEN_PC   = 9'd4;
  localparam logic [8:0] LEN_BR   = 9'd128;
  localparam logic [8:0] LEN_DM   = 9'd128;
  localparam logic [8:0] LEN_DUMP = 9'd260;
  localparam logic [8:0] BASE_BR  = LEN_PC;
  localparam logic [8:0] BASE_DM  = LEN_PC + LEN_BR;
  // The dump is one byte stream PC|BR|DM; the visible send state follows the byte pointer.
  function automatic logic [9:0] send_state(input logic [8:0] p);
    return p < BASE_BR ? S_SEND_PC : p < BASE_DM ? S_SEND_BR : S_SEND_DM;
  endfunction
endpackage

// File: rtl/top_of_tops_debug_soc_mini_core.sv
// mini_core: single-cycle ADDI/SW/HALT core with byte-loadable IM and a flat dump read port
module mini_core import top_of_tops_debug_soc_pkg::*; #(
  parameter int BYTE    = 8,
  parameter int DWORD   = 32,
  parameter int ADDR    = 5,
  parameter int RB_ADDR = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hold,
  input  logic             clr,
  input  logic             step,
  input  logic             im_we,
  input  logic [7:0]       im_idx,
  input  logic [BYTE-1:0]  im_data,
  input  logic [6:0]       rd_idx,
  output logic [DWORD-1:0] rd_word,
  output logic             hlt,
  output logic             halt_fetch
);
  logic [DWORD-1:0] im [64];
  logic [DWORD-1:0] rb [2**RB_ADDR];
  logic [DWORD-1:0] dm [2**ADDR];
  logic [7:0] pc;
  logic [DWORD-1:0] instr, imm, sum;
  logic [5:0] op;
  logic [RB_ADDR-1:0] rs, rt;
  logic [1:0] lane;
  logic [6:0] ri;
  assign instr = im[pc[7:2]];
  assign op = instr[DWORD-1 -: 6];
  assign rs = instr[21 +: RB_ADDR];
  assign rt = instr[16 +: RB_ADDR];
  assign imm = {{(DWORD-16){instr[15]}}, instr[15:0]};
  assign sum = rb[rs] + imm;
  assign halt_fetch = op == OP_HALT;
  assign lane = ~im_idx[1:0];
  assign ri = rd_idx - 7'd1;
  assign rd_word = rd_idx == '0 ? DWORD'(pc) : ri[6:5] == 2'b00 ? rb[ri[RB_ADDR-1:0]] : dm[ri[ADDR-1:0]];
  // Instruction memory: byte-wide loading, most significant byte of each word first
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < 64; i++) im[i] <= '0;
    else if (hold) for (int i = 0; i < 64; i++) im[i] <= '0;
    else if (im_we) im[im_idx[7:2]][int'(lane)*BYTE +: BYTE] <= im_data;
  // Architectural state: PC, halt flag, register bank and data memory
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc <= '0;
      hlt <= 1'b0;
      for (int i = 0; i < 2**RB_ADDR; i++) rb[i] <= '0;
      for (int i = 0; i < 2**ADDR; i++) dm[i] <= '0;
    end else if (hold || clr) begin
      pc <= '0;
      hlt <= 1'b0;
      for (int i = 0; i < 2**RB_ADDR; i++) rb[i] <= '0;
      for (int i = 0; i < 2**ADDR; i++) dm[i] <= '0;
    end else if (step) begin
      if (halt_fetch) hlt <= 1'b1;
      else pc <= pc + 8'd4;
      if (op == OP_ADDI && rt != '0) rb[rt] <= sum;
      if (op == OP_SW) dm[sum[ADDR+1:2]] <= rb[rt];
    end
endmodule

// File: rtl/top_of_tops_debug_soc.sv
// top_of_tops_debug_soc: UART-command debug FSM driving the mini_core execute unit
module top_of_tops_debug_soc import top_of_tops_debug_soc_pkg::*; #(
  parameter int BYTE    = 8,
  parameter int DWORD   = 32,
  parameter int ADDR    = 5,
  parameter int RB_ADDR = 5
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic            i_clock_reset,
  input  logic            i_rx_done,
  input  logic [BYTE-1:0] i_rx_data,
  input  logic            i_tx_done,
  output logic            o_tx_start,
  output logic [BYTE-1:0] o_tx_data,
  output logic            o_hlt,
  output logic [9:0]      o_state
);
  logic [9:0] state, ret;
  logic [8:0] ptr, last, nxt;
  logic [7:0] cmd;
  logic [1:0] lane;
  logic [DWORD-1:0] rd_word;
  logic halt_fetch;
  assign cmd = 8'(i_rx_data);
  assign nxt = ptr + 9'd1;
  assign lane = ~ptr[1:0];
  assign o_state = state;
  mini_core #(.BYTE(BYTE), .DWORD(DWORD), .ADDR(ADDR), .RB_ADDR(RB_ADDR)) u_core (
    .clk(i_clock),
    .rst_n(i_reset),
    .hold(i_clock_reset),
    .clr((state == S_IDLE || state == S_HALTED) && i_rx_done && cmd == CMD_WRITE_IM),
    .step(state == S_RUN || state == S_STEP_EXEC),
    .im_we(state == S_WRITE_IM && i_rx_done),
    .im_idx(ptr[7:0]),
    .im_data(i_rx_data),
    .rd_idx(ptr[8:2]),
    .rd_word(rd_word),
    .hlt(o_hlt),
    .halt_fetch(halt_fetch)
  );
  // Debug FSM: ptr walks the flat PC|BR|DM byte stream up to last, then returns to ret
  always_ff @(posedge i_clock or negedge i_reset)
    if (!i_reset) begin
      state <= S_IDLE;
      ret <= S_IDLE;
      ptr <= '0;
      last <= '0;
      o_tx_start <= 1'b0;
      o_tx_data <= '0;
    end else if (i_clock_reset) begin
      state <= S_IDLE;
      ret <= S_IDLE;
      ptr <= '0;
      last <= '0;
      o_tx_start <= 1'b0;
      o_tx_data <= '0;
    end else begin
      o_tx_start <= 1'b0;
      case (state)
        S_IDLE, S_HALTED: if (i_rx_done) begin
          ret <= state;
          case (cmd)
            CMD_WRITE_IM: begin state <= S_WRITE_IM; ptr <= '0; end
            CMD_RUN: if (state == S_IDLE) state <= S_RUN;
            CMD_STEP: state <= S_STEP;
            CMD_SEND_BR: begin state <= S_SEND_BR; ptr <= BASE_BR; last <= BASE_DM; end
            CMD_SEND_DM: begin state <= S_SEND_DM; ptr <= BASE_DM; last <= LEN_DUMP; end
            CMD_SEND_PC: begin state <= S_SEND_PC; ptr <= '0; last <= LEN_PC; end
            default: ;
          endcase
        end
        S_WRITE_IM: if (i_rx_done) begin
          ptr <= nxt;
          if (ptr == 9'd255) state <= S_IDLE;
        end
        S_RUN: if (halt_fetch) begin
          state <= S_SEND_PC;
          ptr <= '0;
          last <= LEN_DUMP;
          ret <= S_HALTED;
        end
        S_STEP: if (i_rx_done) state <= cmd == CMD_STEP_GO ? S_STEP_EXEC : S_IDLE;
        S_STEP_EXEC: begin
          state <= S_SEND_PC;
          ptr <= '0;
          last <= LEN_DUMP;
          ret <= halt_fetch ? S_HALTED : S_STEP;
        end
        S_SEND_PC, S_SEND_BR, S_SEND_DM: begin
          o_tx_start <= 1'b1;
          o_tx_data <= rd_word[int'(lane)*BYTE +: BYTE];
          state <= S_WAIT_TX;
        end
        S_WAIT_TX: if (i_tx_done) begin
          ptr <= nxt;
          state <= nxt == last ? ret : send_state(nxt);
        end
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_top_of_tops_debug_soc.sv
// tb_top_of_tops_debug_soc: directed, table-driven and random checks against an ISA-level model
module tb_top_of_tops_debug_soc;
  localparam logic [9:0] ST_IDLE = 10'h001, ST_STEP = 10'h008, ST_WAIT = 10'h100, ST_HALT = 10'h200;
  logic clk = 0, rst_n = 0, hold = 0, rx_done = 0, tx_done = 0;
  logic [7:0] rx_data = 0;
  logic tx_start, hlt;
  logic [7:0] tx_data;
  logic [9:0] st;
  int total = 0, bad = 0, s;
  logic [31:0] img [64];
  logic [7:0] got [260];
  int got_n;
  logic [31:0] m_pc;
  logic [31:0] m_r [32];
  logic [31:0] m_dm [32];
  bit m_hlt;
  logic [7:0] first;

  typedef struct { logic [7:0] cmd; int start; int n; logic [9:0] st; } vec_t;
  vec_t v [6];

  top_of_tops_debug_soc dut (
    .i_clock(clk), .i_reset(rst_n), .i_clock_reset(hold), .i_rx_done(rx_done), .i_rx_data(rx_data),
    .i_tx_done(tx_done), .o_tx_start(tx_start), .o_tx_data(tx_data), .o_hlt(hlt), .o_state(st)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, got timeout want finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_done = 1;
    rx_data = b;
    @(negedge clk);
    rx_done = 0;
  endtask

  task automatic load();
    send(8'd1);
    for (int i = 0; i < 256; i++) send(8'(img[i/4] >> (8*(3 - i%4))));
  endtask

  task automatic quiet(input int cyc, output int n);
    n = 0;
    repeat (cyc) begin
      @(negedge clk);
      if (tx_start) n++;
    end
  endtask

  task automatic wait_start(output bit ok);
    int c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!tx_start && c < 3000);
    ok = tx_start;
  endtask

  task automatic collect(input int n);
    bit ok;
    got_n = 0;
    for (int i = 0; i < n; i++) begin
      wait_start(ok);
      if (!ok) begin
        total++;
        bad++;
        $display("FAIL tx_wait: byte %0d got no o_tx_start want pulse", i);
        return;
      end
      got[got_n] = tx_data;
      got_n++;
      tx_done = 1;
      @(negedge clk);
      tx_done = 0;
    end
  endtask

  task automatic model_reset();
    m_pc = 0;
    m_hlt = 0;
    for (int i = 0; i < 32; i++) begin
      m_r[i] = 0;
      m_dm[i] = 0;
    end
  endtask

  task automatic model_step();
    logic [31:0] w, se;
    w = img[m_pc / 4];
    se = {{16{w[15]}}, w[15:0]};
    if (w[31:26] == 6'h3f) m_hlt = 1;
    else begin
      if (w[31:26] == 6'h08 && w[20:16] != 0) m_r[w[20:16]] = m_r[w[25:21]] + se;
      else if (w[31:26] == 6'h2b) m_dm[((m_r[w[25:21]] + se) / 4) % 32] = m_r[w[20:16]];
      m_pc = (m_pc + 4) % 256;
    end
  endtask

  task automatic model_run();
    int g = 0;
    while (!m_hlt && g < 10000) begin
      model_step();
      g++;
    end
  endtask

  function automatic logic [7:0] exp_byte(input int k);
    logic [31:0] w;
    int q = k / 4;
    w = q == 0 ? m_pc : q <= 32 ? m_r[q-1] : m_dm[q-33];
    return 8'(w >> (8*(3 - k%4)));
  endfunction

  task automatic check_dump(input string name, input int start, input int n);
    int e = -1;
    for (int k = 0; k < got_n; k++) if (e < 0 && got[k] !== exp_byte(start + k)) e = k;
    total++;
    if (got_n != n) begin
      bad++;
      $display("FAIL %s: got %0d bytes want %0d", name, got_n, n);
    end else if (e >= 0) begin
      bad++;
      $display("FAIL %s: byte %0d got %02h want %02h", name, e, got[e], exp_byte(start + e));
    end
  endtask

  function automatic logic [31:0] word_at(input int k);
    return {got[k], got[k+1], got[k+2], got[k+3]};
  endfunction

  task automatic gen();
    int h = $urandom_range(8, 40);
    int op;
    for (int i = 0; i < 64; i++) img[i] = 0;
    for (int i = 0; i < h; i++) begin
      op = $urandom_range(0, 2);
      if (op == 0) img[i] = {6'h08, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
      else if (op == 1) img[i] = {6'h2b, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
      else begin
        op = $urandom_range(0, 62);
        if (op == 8 || op == 43) op = 0;
        img[i] = {6'(op), 26'($urandom)};
      end
    end
    img[h] = {6'h3f, 26'($urandom)};
  endtask

  initial begin
    tick(3);
    rst_n = 1;
    tick(2);
    chk("reset state", 32'(st), 32'(ST_IDLE));
    chk("reset hlt", 32'(hlt), 0);
    chk("reset tx_data", 32'(tx_data), 0);
    quiet(5, s);
    chk("reset tx_start", s, 0);

    for (int i = 0; i < 64; i++) img[i] = 0;
    img[0] = 32'h20010005;
    img[1] = 32'hAC010004;
    img[2] = 32'hFC000000;
    load();
    chk("load state", 32'(st), 32'(ST_IDLE));
    send(8'd2);
    collect(260);
    model_reset();
    model_run();
    check_dump("run dump", 0, 260);
    chk("run pc", word_at(0), 32'd8);
    chk("run r1", word_at(8), 32'd5);
    chk("run dm1", word_at(136), 32'd5);
    quiet(5, s);
    chk("run extra tx", s, 0);
    chk("run hlt", 32'(hlt), 1);
    chk("run state", 32'(st), 32'(ST_HALT));

    v[0] = '{8'd6, 0, 4, ST_HALT};
    v[1] = '{8'd4, 4, 128, ST_HALT};
    v[2] = '{8'd5, 132, 128, ST_HALT};
    v[3] = '{8'd2, 0, 0, ST_HALT};
    v[4] = '{8'd0, 0, 0, ST_HALT};
    v[5] = '{8'hff, 0, 0, ST_HALT};
    for (int i = 0; i < 6; i++) begin
      send(v[i].cmd);
      if (v[i].n > 0) begin
        collect(v[i].n);
        check_dump($sformatf("vec%0d dump", i), v[i].start, v[i].n);
      end
      quiet(10, s);
      chk($sformatf("vec%0d extra tx", i), s, 0);
      chk($sformatf("vec%0d state", i), 32'(st), 32'(v[i].st));
    end

    load();
    chk("reload hlt", 32'(hlt), 0);
    model_reset();
    send(8'd3);
    chk("step state", 32'(st), 32'(ST_STEP));
    send(8'd7);
    collect(260);
    model_step();
    check_dump("step1 dump", 0, 260);
    chk("step1 pc", word_at(0), 32'd4);
    chk("step1 r1", word_at(8), 32'd5);
    tick(3);
    chk("step1 hlt", 32'(hlt), 0);
    chk("step1 state", 32'(st), 32'(ST_STEP));
    send(8'd7);
    collect(260);
    model_step();
    check_dump("step2 dump", 0, 260);
    send(8'd7);
    collect(260);
    model_step();
    check_dump("step3 dump", 0, 260);
    chk("step3 pc", word_at(0), 32'd8);
    tick(3);
    chk("step3 hlt", 32'(hlt), 1);
    chk("step3 state", 32'(st), 32'(ST_HALT));

    load();
    send(8'd3);
    send(8'd9);
    tick(2);
    chk("step abort state", 32'(st), 32'(ST_IDLE));
    send(8'd6);
    collect(4);
    model_reset();
    check_dump("step abort pc", 0, 4);

    send(8'd6);
    begin
      bit ok;
      wait_start(ok);
      chk("withhold start seen", 32'(ok), 1);
      first = tx_data;
      quiet(10, s);
      send(8'd2);
      send(8'd3);
      begin
        int s2;
        quiet(10, s2);
        s += s2;
      end
      chk("withhold no repeat", s, 0);
      chk("withhold state", 32'(st), 32'(ST_WAIT));
      chk("withhold data stable", 32'(tx_data), 32'(first));
      tx_done = 1;
      @(negedge clk);
      tx_done = 0;
      collect(3);
      check_dump("withhold tail", 1, 3);
      quiet(5, s);
      chk("withhold end state", 32'(st), 32'(ST_IDLE));
      chk("withhold rx ignored", 32'(hlt), 0);
    end

    send(8'd1);
    for (int i = 0; i < 100; i++) send(8'($urandom));
    #2 rst_n = 0;
    #1 chk("midload reset state", 32'(st), 32'(ST_IDLE));
    tick(2);
    rst_n = 1;
    tick(2);
    chk("after reset state", 32'(st), 32'(ST_IDLE));
    send(8'd6);
    collect(4);
    model_reset();
    check_dump("after reset pc", 0, 4);
    gen();
    load();
    send(8'd2);
    collect(260);
    model_reset();
    model_run();
    check_dump("fresh load dump", 0, 260);

    hold = 1;
    tick(2);
    send(8'd2);
    chk("hold state", 32'(st), 32'(ST_IDLE));
    chk("hold hlt", 32'(hlt), 0);
    hold = 0;
    send(8'd6);
    collect(4);
    model_reset();
    check_dump("hold pc", 0, 4);

    for (int r = 0; r < 3; r++) begin
      gen();
      load();
      send(8'd2);
      collect(260);
      model_reset();
      model_run();
      check_dump($sformatf("rand%0d dump", r), 0, 260);
      quiet(3, s);
      chk($sformatf("rand%0d state", r), 32'(st), 32'(ST_HALT));
    end

    gen();
    load();
    model_reset();
    send(8'd3);
    for (int r = 0; r < 3; r++) begin
      send(8'd7);
      collect(260);
      model_step();
      check_dump($sformatf("rstep%0d dump", r), 0, 260);
      quiet(3, s);
      chk($sformatf("rstep%0d state", r), 32'(st), m_hlt ? 32'(ST_HALT) : 32'(ST_STEP));
      if (m_hlt) break;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
